clr_st_classify: RTL and testbench

Classifies a signed measurement stream into the 2-bit color state `clrst` consumed by the display color mapper: 00 large negative (red), 01 small negative (orange), 10 small positive (light blue), 11 large positive (blue). The block sits between the signal processing path and the display logic. It applies a magnitude threshold with hysteresis, plus a dwell filter, so the on-screen color does not flicker when the signal sits near a boundary.

---
 rtl/clr_st_pkg.sv | 13 +
 rtl/clr_st_bnd_cmp.sv | 24 ++
 rtl/clr_st_classify.sv | 148 ++++++++++++++
 tb/tb_clr_st_classify.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clr_st_pkg.sv
// Shared color-state codes for the measurement color classifier.
package clr_st_pkg;

    typedef enum logic [1:0] {
        CLR_ST_NEG_BIG = 2'b00,
        CLR_ST_NEG_SML = 2'b01,
        CLR_ST_POS_SML = 2'b10,
        CLR_ST_POS_BIG = 2'b11
    } clr_st_e;

    localparam clr_st_e CLR_ST_RST = CLR_ST_POS_SML;

endpackage

// File: rtl/clr_st_bnd_cmp.sv
// One boundary of the classifier: is the sample above boundary bnd, with the
// hysteresis band shifted toward whichever side the current state sits on.
module clr_st_bnd_cmp #(
    parameter int W = 16
) (
    input  logic signed [W+1:0] bnd,
    input  logic        [W-2:0] h,
    input  logic                above,
    input  logic signed [W-1:0] smp,
    output logic                abv
);

    logic signed [W+1:0] h_x;
    logic signed [W+1:0] smp_x;
    logic signed [W+1:0] lim;

    always_comb begin
        h_x   = $signed({3'b000, h});
        smp_x = $signed({{2{smp[W-1]}}, smp});
        lim   = above ? (bnd - h_x) : (bnd + h_x);
        abv   = (smp_x >= lim);
    end

endmodule

// File: rtl/clr_st_classify.sv
// Signed sample -> 2-bit display color state, with hysteresis and an optional
// dwell filter enabled by the CLR_ST_DWELL_EN macro.
module clr_st_classify
    import clr_st_pkg::*;
#(
    parameter int W      = 16,
    parameter int HOLD_N = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] sig,
    input  logic                sig_vld,
    input  logic        [W-2:0] thr,
    input  logic        [W-2:0] hyst,
    output logic        [1:0]   clrst,
    output logic                clrst_chg
);

    if (HOLD_N < 1 || HOLD_N > 65535) begin : g_hold_range
        $error("clr_st_classify: HOLD_N must be within 1..65535");
    end

    // Clamping h to thr/2 keeps the three hysteresis bands ordered.
    function automatic logic [W-2:0] clamp_hyst(input logic [W-2:0] hy,
                                                input logic [W-2:0] th);
        logic [W-2:0] half;
        half = th >> 1;
        return (hy < half) ? hy : half;
    endfunction

    logic signed [W-1:0] sig_p1_q, sig_p1_d;
    logic        [W-2:0] thr_p1_q, thr_p1_d;
    logic        [W-2:0] h_p1_q, h_p1_d;
    logic                vld_p1_q, vld_p1_d;

    always_comb begin
        sig_p1_d = sig_p1_q;
        thr_p1_d = thr_p1_q;
        h_p1_d   = h_p1_q;
        vld_p1_d = sig_vld;
        if (sig_vld) begin
            sig_p1_d = sig;
            thr_p1_d = thr;
            h_p1_d   = clamp_hyst(hyst, thr);
        end
    end

    always_ff @(posedge clk) begin
        sig_p1_q <= sig_p1_d;
        thr_p1_q <= thr_p1_d;
        h_p1_q   <= h_p1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p1_q <= 1'b0;
        else     vld_p1_q <= vld_p1_d;
    end

    // ---- stage 1 -> stage 2: candidate state and state update ----
    clr_st_e             clrst_q, clrst_d;
    logic                clrst_chg_q, clrst_chg_d;
    logic signed [W+1:0] thr_x;
    logic signed [W+1:0] bnd [3];
    logic        [2:0]   abv;
    logic        [1:0]   cand;

    always_comb begin
        thr_x  = $signed({3'b000, thr_p1_q});
        bnd[0] = -thr_x;
        bnd[1] = '0;
        bnd[2] = thr_x;
    end

    for (genvar k = 0; k < 3; k++) begin : g_bnd
        clr_st_bnd_cmp #(.W(W)) u_cmp (
            .bnd   (bnd[k]),
            .h     (h_p1_q),
            .above (clrst_q > 2'(k)),
            .smp   (sig_p1_q),
            .abv   (abv[k])
        );
    end

    always_comb cand = {1'b0, abv[0]} + {1'b0, abv[1]} + {1'b0, abv[2]};

`ifdef CLR_ST_DWELL_EN
    localparam int CW = $clog2(HOLD_N + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    pend_q, pend_d;

    always_comb begin
        clrst_d     = clrst_q;
        clrst_chg_d = 1'b0;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        cnt_inc     = '0;
        if (vld_p1_q) begin
            if (cand == clrst_q) begin
                cnt_d = '0;
            end else begin
                cnt_inc = (cand == pend_q) ? (cnt_q + 1'b1) : CW'(1);
                pend_d  = cand;
                if (cnt_inc == CW'(HOLD_N)) begin
                    clrst_d     = clr_st_e'(cand);
                    clrst_chg_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= CLR_ST_RST;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end
`else
    always_comb begin
        clrst_d     = clrst_q;
        clrst_chg_d = 1'b0;
        if (vld_p1_q && (cand != clrst_q)) begin
            clrst_d     = clr_st_e'(cand);
            clrst_chg_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            clrst_q     <= CLR_ST_RST;
            clrst_chg_q <= 1'b0;
        end else begin
            clrst_q     <= clrst_d;
            clrst_chg_q <= clrst_chg_d;
        end
    end

    assign clrst     = clrst_q;
    assign clrst_chg = clrst_chg_q;

endmodule

// File: tb/tb_clr_st_classify.sv
// Directed scoreboard bench for clr_st_classify: dut_a runs with HOLD_N=1,
// dut_b with HOLD_N=4 (dwell build) or 1024 (dwell disabled).
module tb_clr_st_classify;

    localparam int W = 16;
`ifdef CLR_ST_DWELL_EN
    localparam int HB = 4;
`else
    localparam int HB = 1024;
`endif

    typedef struct {
        int         due;
        bit         dut;
        logic [1:0] st;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic signed [W-1:0] a_sig, b_sig;
    logic                a_vld, b_vld;
    logic        [W-2:0] a_thr, a_hyst, b_thr, b_hyst;
    logic        [1:0]   a_st, b_st;
    logic                a_chg, b_chg;

    clr_st_classify #(.W(W), .HOLD_N(1)) dut_a (
        .clk(clk), .rst(rst), .sig(a_sig), .sig_vld(a_vld),
        .thr(a_thr), .hyst(a_hyst), .clrst(a_st), .clrst_chg(a_chg)
    );

    clr_st_classify #(.W(W), .HOLD_N(HB)) dut_b (
        .clk(clk), .rst(rst), .sig(b_sig), .sig_vld(b_vld),
        .thr(b_thr), .hyst(b_hyst), .clrst(b_st), .clrst_chg(b_chg)
    );

    int         total = 0;
    int         bad   = 0;
    int         ncyc  = 0;
    logic [1:0] exp_a, exp_b;
    logic       exp_ach, exp_bch;
    ev_t        q[$];

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, req, ncyc);
        end
    endtask

    // Advance one clock, retire due scoreboard entries, compare both DUTs.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        ncyc++;
        exp_ach = 1'b0;
        exp_bch = 1'b0;
        if (rst) begin
            exp_a = 2'b10;
            exp_b = 2'b10;
            q.delete();
        end else begin
            while (q.size() > 0 && q[0].due == ncyc) begin
                e = q.pop_front();
                if (e.dut) begin
                    exp_b   = e.st;
                    exp_bch = 1'b1;
                end else begin
                    exp_a   = e.st;
                    exp_ach = 1'b1;
                end
            end
        end
        chk("a_clrst", a_st, exp_a);
        chk("a_chg", {1'b0, a_chg}, {1'b0, exp_ach});
        chk("b_clrst", b_st, exp_b);
        chk("b_chg", {1'b0, b_chg}, {1'b0, exp_bch});
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input bit dut, input logic [1:0] st);
        ev_t e;
        e.due = ncyc + 2;
        e.dut = dut;
        e.st  = st;
        q.push_back(e);
    endtask

    task automatic samp_a(input int s, input bit chg, input logic [1:0] st);
        a_sig = W'(s);
        a_vld = 1'b1;
        if (chg) push(1'b0, st);
        tick();
        a_vld = 1'b0;
    endtask

    task automatic samp_b(input int s, input bit chg, input logic [1:0] st);
        b_sig = W'(s);
        b_vld = 1'b1;
        if (chg) push(1'b1, st);
        tick();
        b_vld = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        a_vld  = 1'b0;
        b_vld  = 1'b0;
        a_sig  = '0;
        b_sig  = '0;
        a_thr  = 15'd1000;
        a_hyst = 15'd100;
        b_thr  = 15'd1000;
        b_hyst = 15'd100;
        exp_a  = 2'b10;
        exp_b  = 2'b10;
        tick();
        tick();
        rst = 1'b0;
        idle(1);

        // basic classification, narrow hysteresis
        a_hyst = 15'd20;
        samp_a(-50, 1, 2'b01);   idle(2);
        samp_a(-2000, 1, 2'b00); idle(2);
        samp_a(1500, 1, 2'b11);  idle(2);

        // hysteresis around +thr, back-to-back samples
        a_hyst = 15'd100;
        samp_a(500, 1, 2'b10);
        samp_a(1050, 0, 2'b00);
        samp_a(1100, 1, 2'b11);
        samp_a(950, 0, 2'b00);
        samp_a(899, 1, 2'b10);
        idle(2);

        // thr = 0 collapses the small bands
        a_thr = 15'd0;
        samp_a(5, 1, 2'b11);
        samp_a(-1, 1, 2'b00);
        samp_a(0, 1, 2'b11);
        idle(2);

        // full-scale sample, threshold and hysteresis
        a_thr  = 15'd32767;
        a_hyst = 15'd32767;
        samp_a(-32768, 1, 2'b01);
        samp_a(32767, 1, 2'b10);
        idle(2);

        // reset together with a sample, then reset one cycle after a sample
        a_thr  = 15'd1000;
        a_hyst = 15'd100;
        rst    = 1'b1;
        a_sig  = -16'sd5000;
        a_vld  = 1'b1;
        tick();
        rst   = 1'b0;
        a_vld = 1'b0;
        idle(3);
        samp_a(-5000, 1, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

`ifdef CLR_ST_DWELL_EN
        // interrupted dwell restarts the count
        repeat (3) begin samp_b(-5000, 0, 2'b00); idle(1); end
        samp_b(10, 0, 2'b00); idle(1);
        repeat (3) begin samp_b(-5000, 0, 2'b00); idle(1); end
        samp_b(-5000, 1, 2'b00); idle(2);

        // switching pending candidate restarts the count at 1
        samp_b(5000, 0, 2'b00);
        samp_b(5000, 0, 2'b00);
        samp_b(500, 0, 2'b00);
        samp_b(5000, 0, 2'b00);
        samp_b(5000, 0, 2'b00);
        samp_b(5000, 0, 2'b00);
        samp_b(5000, 1, 2'b11);
        idle(2);

        // reset mid-dwell discards progress
        repeat (3) samp_b(-5000, 0, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) samp_b(-5000, 0, 2'b00);
        samp_b(-5000, 1, 2'b00);
        idle(3);
`else
        // without the dwell filter HOLD_N is ignored
        samp_b(-2000, 1, 2'b00); idle(3);
        samp_b(10, 1, 2'b01);    idle(2);
        samp_b(-5000, 1, 2'b00);
        samp_b(-4000, 0, 2'b00);
        idle(3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
